// File: rtl/adc_pkg.sv
// -----------------------------------------------------------------------------
// adc_pkg
// Shared types and constants for the ADC lane alignment controller.
//   state_t      : alignment FSM state encoding
//   ROT_W        : width of the deserialized word / rotation compare (6)
//   PATTERN_DEF  : default ADC training word
//   MAXTAP_DEF   : default highest IODELAY tap swept
//   TAP_W        : IODELAY tap counter width
//   mid_tap()    : window centre, (lo+hi)>>1 computed with one extra bit
// -----------------------------------------------------------------------------
package adc_pkg;

   localparam int               ROT_W       = 6;
   localparam int               TAP_W       = 8;
   localparam logic [ROT_W-1:0] PATTERN_DEF = 6'b111000;
   localparam int               MAXTAP_DEF  = 255;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_SRES,
      ST_DRES,
      ST_WAIT,
      ST_CHECK,
      ST_INC,
      ST_RECEN,
      ST_CENTER,
      ST_SLIP,
      ST_DONE,
      ST_FAIL
   } state_t;

   // The sum can reach 2*MAXTAP, so it is formed one bit wider than a tap
   // before halving; otherwise a window near the top of the range wraps.
   function automatic logic [TAP_W-1:0] mid_tap(input logic [TAP_W-1:0] lo,
                                                input logic [TAP_W-1:0] hi);
      logic [TAP_W:0] sum;
      sum = {1'b0, lo} + {1'b0, hi};
      return sum[TAP_W:1];
   endfunction

endpackage

// File: rtl/adc_word_check.sv
// -----------------------------------------------------------------------------
// adc_word_check
// Judges one IODELAY tap. While en is high it samples din every cycle: the
// first word must be one of the ROT_W rotations of PATTERN, every later word
// must equal the first. NSAMP consecutive good words raise pass for one
// cycle; the first bad word raises fail for one cycle. Dropping en clears the
// run so every tap starts fresh.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   en         : sampling window (controller is in its CHECK state)
//   din[5:0]   : deserialized word
//   pass, fail : single-cycle verdict strobes (combinational on din)
// -----------------------------------------------------------------------------
module adc_word_check
   import adc_pkg::*;
#(
   parameter logic [ROT_W-1:0] PATTERN = PATTERN_DEF,
   parameter int               NSAMP   = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [ROT_W-1:0] din,
   output logic             pass,
   output logic             fail
);

   localparam int                 CNT_W = $clog2(NSAMP + 1);
   localparam logic [CNT_W-1:0]   LAST  = CNT_W'(NSAMP - 1);
   // Doubling the pattern lets every left-rotation be taken as a slice.
   localparam logic [2*ROT_W-1:0] PAT2  = {PATTERN, PATTERN};

   logic [ROT_W-1:0] rot_hit;
   logic [CNT_W-1:0] cnt_reg, cnt_next;
   logic [ROT_W-1:0] prev_reg, prev_next;
   logic             match_ok;

   for (genvar gi = 0; gi < ROT_W; gi++) begin : g_rot
      assign rot_hit[gi] = (din == PAT2[2*ROT_W-1-gi -: ROT_W]);
   end

   always_comb begin
      cnt_next  = cnt_reg;
      prev_next = prev_reg;
      pass      = 1'b0;
      fail      = 1'b0;
      // Only the first word needs the rotation compare; afterwards equality
      // with that word implies it.
      match_ok  = (cnt_reg == '0) ? (|rot_hit) : (din == prev_reg);
      if (!en) begin
         cnt_next = '0;
      end else if (!match_ok) begin
         fail     = 1'b1;
         cnt_next = '0;
      end else if (cnt_reg == LAST) begin
         pass     = 1'b1;
         cnt_next = '0;
      end else begin
         cnt_next  = cnt_reg + 1'b1;
         prev_next = din;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_reg  <= '0;
         prev_reg <= '0;
      end else begin
         cnt_reg  <= cnt_next;
         prev_reg <= prev_next;
      end
   end

endmodule

// File: rtl/adc_align_ctrl.sv
// -----------------------------------------------------------------------------
// adc_align_ctrl
// Aligns one ADC LVDS lane: resets ISERDES and IODELAY, sweeps every IODELAY
// tap looking for the window where the training word is stable, re-centres
// the delay in the middle of that window, then bitslips until the word equals
// PATTERN exactly.
// Ports:
//   CLK        : clock (also IODELAY DCLK)
//   RST        : asynchronous active-high reset
//   START      : one-cycle pulse, accepted in IDLE, DONE or FAIL
//   DIN[5:0]   : deserialized word
//   SRST       : ISERDES reset pulse
//   DRST       : IODELAY reset pulse
//   DINC       : IODELAY increment pulse
//   BS         : bitslip pulse
//   TAP[7:0]   : current IODELAY tap
//   DONE, FAIL : result levels
//   WIN[15:0]  : {HI,LO} of the passing window, only when ADC_ALIGN_DEBUG_EN
//                is defined; valid from RECEN onward, cleared on START/RST
// Build option: ADC_ALIGN_DEBUG_EN adds the WIN debug port.
// -----------------------------------------------------------------------------
module adc_align_ctrl
   import adc_pkg::*;
#(
   parameter logic [ROT_W-1:0] PATTERN = PATTERN_DEF,
   parameter int               NSAMP   = 16,
   parameter int               SETTLE  = 8,
   parameter int               MAXTAP  = MAXTAP_DEF
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic               START,
   input  logic [ROT_W-1:0]   DIN,
   output logic               SRST,
   output logic               DRST,
   output logic               DINC,
   output logic               BS,
   output logic [TAP_W-1:0]   TAP,
   output logic               DONE,
   output logic               FAIL
`ifdef ADC_ALIGN_DEBUG_EN
   ,
   output logic [2*TAP_W-1:0] WIN
`endif
);

   localparam int               SET_W     = $clog2(SETTLE + 1);
   localparam logic [SET_W-1:0] SET_LAST  = SET_W'(SETTLE - 1);
   localparam logic [TAP_W-1:0] TAP_MAX   = TAP_W'(MAXTAP);
   localparam logic [2:0]       SLIP_LAST = 3'(ROT_W);

   state_t           state_reg, state_next;
   state_t           ret_reg, ret_next;
   logic [TAP_W-1:0] tap_reg, tap_next;
   logic [TAP_W-1:0] lo_reg, lo_next;
   logic [TAP_W-1:0] hi_reg, hi_next;
   logic             lo_valid_reg, lo_valid_next;
   logic [TAP_W-1:0] center_reg, center_next;
   logic [2:0]       slip_reg, slip_next;
   logic [SET_W-1:0] settle_reg, settle_next;

   logic             chk_en;
   logic             chk_pass;
   logic             chk_fail;
   logic             start_ok;
   logic [TAP_W-1:0] tap_inc;

   adc_word_check #(
      .PATTERN (PATTERN),
      .NSAMP   (NSAMP)
   ) u_word_check (
      .clk  (CLK),
      .rst  (RST),
      .en   (chk_en),
      .din  (DIN),
      .pass (chk_pass),
      .fail (chk_fail)
   );

   assign start_ok = START && ((state_reg == ST_IDLE) ||
                               (state_reg == ST_DONE) ||
                               (state_reg == ST_FAIL));

   // The tap counter mirrors the IODELAY and must never wrap.
   assign tap_inc  = (tap_reg == TAP_MAX) ? tap_reg : tap_reg + 1'b1;

   always_comb begin
      state_next    = state_reg;
      ret_next      = ret_reg;
      tap_next      = tap_reg;
      lo_next       = lo_reg;
      hi_next       = hi_reg;
      lo_valid_next = lo_valid_reg;
      center_next   = center_reg;
      slip_next     = slip_reg;
      settle_next   = '0;
      chk_en        = 1'b0;
      SRST          = 1'b0;
      DRST          = 1'b0;
      DINC          = 1'b0;
      BS            = 1'b0;

      case (state_reg)
         ST_IDLE, ST_DONE, ST_FAIL: begin
            if (start_ok) begin
               state_next    = ST_SRES;
               tap_next      = '0;
               lo_next       = '0;
               hi_next       = '0;
               lo_valid_next = 1'b0;
               center_next   = '0;
               slip_next     = '0;
            end
         end

         ST_SRES: begin
            SRST       = 1'b1;
            state_next = ST_DRES;
         end

         ST_DRES: begin
            DRST       = 1'b1;
            tap_next   = '0;
            ret_next   = ST_CHECK;
            state_next = ST_WAIT;
         end

         // DIN is deliberately not looked at while the delay line settles.
         ST_WAIT: begin
            if (settle_reg == SET_LAST) begin
               state_next = ret_reg;
            end else begin
               settle_next = settle_reg + 1'b1;
            end
         end

         ST_CHECK: begin
            chk_en = 1'b1;
            if (chk_pass) begin
               if (!lo_valid_reg) begin
                  lo_next       = tap_reg;
                  lo_valid_next = 1'b1;
               end
               hi_next    = tap_reg;
               state_next = (tap_reg == TAP_MAX) ? ST_RECEN : ST_INC;
            end else if (chk_fail) begin
               // A failing tap after the window opened closes it; without a
               // window the sweep carries on to the last tap.
               if (lo_valid_reg) begin
                  state_next = ST_RECEN;
               end else if (tap_reg == TAP_MAX) begin
                  state_next = ST_FAIL;
               end else begin
                  state_next = ST_INC;
               end
            end
         end

         ST_INC: begin
            DINC       = 1'b1;
            tap_next   = tap_inc;
            ret_next   = ST_CHECK;
            state_next = ST_WAIT;
         end

         ST_RECEN: begin
            DRST        = 1'b1;
            tap_next    = '0;
            center_next = mid_tap(lo_reg, hi_reg);
            ret_next    = ST_CENTER;
            state_next  = ST_WAIT;
         end

         // Each step is DINC followed by a settle wait, so a zero target
         // passes straight through to SLIP without any increment.
         ST_CENTER: begin
            if (tap_reg != center_reg) begin
               DINC       = 1'b1;
               tap_next   = tap_inc;
               ret_next   = ST_CENTER;
               state_next = ST_WAIT;
            end else begin
               state_next = ST_SLIP;
            end
         end

         ST_SLIP: begin
            if (DIN == PATTERN) begin
               state_next = ST_DONE;
            end else if (slip_reg == SLIP_LAST) begin
               state_next = ST_FAIL;
            end else begin
               BS         = 1'b1;
               slip_next  = slip_reg + 1'b1;
               ret_next   = ST_SLIP;
               state_next = ST_WAIT;
            end
         end

         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_reg    <= ST_IDLE;
         ret_reg      <= ST_CHECK;
         tap_reg      <= '0;
         lo_reg       <= '0;
         hi_reg       <= '0;
         lo_valid_reg <= 1'b0;
         center_reg   <= '0;
         slip_reg     <= '0;
         settle_reg   <= '0;
      end else begin
         state_reg    <= state_next;
         ret_reg      <= ret_next;
         tap_reg      <= tap_next;
         lo_reg       <= lo_next;
         hi_reg       <= hi_next;
         lo_valid_reg <= lo_valid_next;
         center_reg   <= center_next;
         slip_reg     <= slip_next;
         settle_reg   <= settle_next;
      end
   end

   assign TAP  = tap_reg;
   assign DONE = (state_reg == ST_DONE);
   assign FAIL = (state_reg == ST_FAIL);

`ifdef ADC_ALIGN_DEBUG_EN
   logic [2*TAP_W-1:0] win_reg;

   // Snapshot taken when the window is final, so it stays stable through
   // centring and bitslip.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         win_reg <= '0;
      end else if (start_ok) begin
         win_reg <= '0;
      end else if (state_reg == ST_RECEN) begin
         win_reg <= {hi_reg, lo_reg};
      end
   end

   assign WIN = win_reg;
`endif

endmodule

// File: tb/tb_adc_align_ctrl.sv
// -----------------------------------------------------------------------------
// tb_adc_align_ctrl
// Drives adc_align_ctrl against a behavioural IODELAY/ISERDES lane model. Each
// scenario record holds the model's passing window and word rotation together
// with the hand-derived outcome; the record is queued when START is driven
// and compared when DONE or FAIL appears.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_adc_align_ctrl;
   import adc_pkg::*;

   localparam int         SETTLE = 8;
   localparam int         NSAMP  = 16;
   localparam logic [5:0] PAT    = 6'b111000;
   localparam int         NV     = 6;

   typedef struct {
      int lo;        // first passing tap, -1 = never passes
      int hi;
      int rot;       // initial word rotation
      bit stuck;     // bitslip has no effect
      int glitch;    // tap with one glitched word, -1 = none
      bit exp_done;
      int exp_tap;
      int exp_dinc;
      int exp_bs;
      int exp_drst;
      int exp_win;
   } vec_t;

   logic       CLK = 1'b0;
   logic       RST;
   logic       START;
   logic [5:0] DIN;
   logic       SRST, DRST, DINC, BS, DONE, FAIL;
   logic [7:0] TAP;
`ifdef ADC_ALIGN_DEBUG_EN
   logic [15:0] WIN;
`endif

   adc_align_ctrl #(
      .PATTERN (PAT),
      .NSAMP   (NSAMP),
      .SETTLE  (SETTLE),
      .MAXTAP  (255)
   ) dut (
      .CLK   (CLK),
      .RST   (RST),
      .START (START),
      .DIN   (DIN),
      .SRST  (SRST),
      .DRST  (DRST),
      .DINC  (DINC),
      .BS    (BS),
      .TAP   (TAP),
      .DONE  (DONE),
      .FAIL  (FAIL)
`ifdef ADC_ALIGN_DEBUG_EN
      ,
      .WIN   (WIN)
`endif
   );

   initial forever #5 CLK = ~CLK;

   // Lane model parameters (written by the main process only)
   int m_lo = -1, m_hi = -1, m_rot_init = 0, m_glitch = -1;
   bit m_stuck = 1'b0;
   int run_id = 0;

   // Lane model state and pulse counters (written by the monitor only)
   int tap_m = 0, rot_m = 0, since_m = 1000, seen_run = 0;
   bit glitch_done = 1'b0;
   int n_srst, n_drst, n_dinc, n_bs, n_overlap, n_pulse, first_p, second_p;

   int   checks = 0;
   int   passes = 0;
   vec_t tbl[NV];
   vec_t sb[$];

   function automatic logic [5:0] rotl(input logic [5:0] w, input int n);
      logic [5:0] r;
      r = w;
      for (int i = 0; i < n; i++) r = {r[4:0], r[5]};
      return r;
   endfunction

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act == exp) passes++;
      else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
   endtask

   // Monitor + lane model: observe pulses at the falling edge, update the
   // modelled IODELAY tap / bitslip phase, then present DIN for next cycle.
   initial begin
      int npul;
      logic [5:0] w;
      DIN = 6'd0;
      n_srst = 0; n_drst = 0; n_dinc = 0; n_bs = 0;
      n_overlap = 0; n_pulse = 0; first_p = 0; second_p = 0;
      forever begin
         @(negedge CLK);
         if (run_id != seen_run) begin
            seen_run = run_id;
            n_srst = 0; n_drst = 0; n_dinc = 0; n_bs = 0;
            n_overlap = 0; n_pulse = 0; first_p = 0; second_p = 0;
            rot_m = m_rot_init;
            glitch_done = 1'b0;
         end
         if (!RST) begin
            npul = int'(SRST) + int'(DRST) + int'(DINC) + int'(BS);
            if (npul > 1) n_overlap++;
            if (npul > 0) begin
               since_m = 0;
               n_pulse++;
               if (n_pulse == 1) first_p  = SRST ? 1 : DRST ? 2 : DINC ? 3 : 4;
               if (n_pulse == 2) second_p = SRST ? 1 : DRST ? 2 : DINC ? 3 : 4;
            end else if (since_m < 1000) begin
               since_m++;
            end
            if (SRST) n_srst++;
            if (DRST) begin n_drst++; tap_m = 0; end
            if (DINC) begin n_dinc++; if (tap_m < 255) tap_m++; end
            if (BS) begin
               n_bs++;
               if (!m_stuck) rot_m = (rot_m + 1) % 6;
            end
         end
         if (since_m < SETTLE) begin
            w = 6'($urandom_range(0, 63));   // unsettled line: junk
         end else if (m_lo >= 0 && tap_m >= m_lo && tap_m <= m_hi) begin
            w = rotl(PAT, rot_m);
            if (tap_m == m_glitch && since_m == SETTLE + 9 && !glitch_done) begin
               w = rotl(PAT, rot_m + 1);
               glitch_done = 1'b1;
            end
         end else begin
            w = 6'b000000;                   // not any rotation of PAT
         end
         DIN = w;
      end
   end

   task automatic start_run(input vec_t v, input bit push);
      @(posedge CLK); #1;
      m_lo = v.lo; m_hi = v.hi; m_rot_init = v.rot;
      m_stuck = v.stuck; m_glitch = v.glitch;
      run_id++;
      START = 1'b1;
      if (push) sb.push_back(v);
      @(posedge CLK); #1;
      START = 1'b0;
      // A START mid-run must be ignored (no second SRST).
      repeat (30) @(posedge CLK);
      #1 START = 1'b1;
      @(posedge CLK); #1;
      START = 1'b0;
   endtask

   task automatic wait_result(input int idx);
      vec_t v;
      int   cyc;
      cyc = 0;
      while (!(DONE || FAIL) && cyc < 20000) begin
         @(posedge CLK); #2;
         cyc++;
      end
      v = sb.pop_front();
      if (!(DONE || FAIL)) begin
         checks++;
         $display("FAIL run%0d_timeout: got no DONE/FAIL after %0d cycles, expected a result", idx, cyc);
         return;
      end
      repeat (2) @(posedge CLK);
      #2;
      chk($sformatf("run%0d_done", idx), int'(DONE), int'(v.exp_done));
      chk($sformatf("run%0d_fail", idx), int'(FAIL), int'(!v.exp_done));
      chk($sformatf("run%0d_tap", idx), int'(TAP), v.exp_tap);
      chk($sformatf("run%0d_iodelay_tap", idx), tap_m, v.exp_tap);
      chk($sformatf("run%0d_dinc", idx), n_dinc, v.exp_dinc);
      chk($sformatf("run%0d_bs", idx), n_bs, v.exp_bs);
      chk($sformatf("run%0d_drst", idx), n_drst, v.exp_drst);
      chk($sformatf("run%0d_srst", idx), n_srst, 1);
      chk($sformatf("run%0d_first_pulse", idx), first_p, 1);
      chk($sformatf("run%0d_second_pulse", idx), second_p, 2);
      chk($sformatf("run%0d_overlap", idx), n_overlap, 0);
`ifdef ADC_ALIGN_DEBUG_EN
      chk($sformatf("run%0d_win", idx), int'(WIN), v.exp_win);
`endif
      $display("run%0d: DONE=%0d FAIL=%0d TAP=%0d DINC=%0d BS=%0d DRST=%0d",
               idx, DONE, FAIL, TAP, n_dinc, n_bs, n_drst);
   endtask

   initial begin
      vec_t rv;
      int   cyc;
      RST   = 1'b1;
      START = 1'b0;

      //           lo   hi  rot stuck glitch done tap dinc bs drst win
      tbl[0] = '{  40,  60, 2, 1'b0,  -1, 1'b1,  50, 111, 4, 2, 60*256+40};
      tbl[1] = '{  40,  60, 0, 1'b0,  45, 1'b1,  42,  87, 0, 2, 44*256+40};
      tbl[2] = '{  -1,  -1, 0, 1'b0,  -1, 1'b0, 255, 255, 0, 1, 0};
      tbl[3] = '{   0,   0, 0, 1'b0,  -1, 1'b1,   0,   1, 0, 2, 0};
      tbl[4] = '{  40,  60, 3, 1'b1,  -1, 1'b0,  50, 111, 6, 2, 60*256+40};
      tbl[5] = '{ 250, 255, 5, 1'b0,  -1, 1'b1, 252, 507, 1, 2, 255*256+250};
      rv     = '{  15,  30, 0, 1'b0,  -1, 1'b1,  22,  53, 0, 2, 30*256+15};

      repeat (3) @(posedge CLK);
      #2;
      chk("reset_pulses", int'({SRST, DRST, DINC, BS}), 0);
      chk("reset_tap", int'(TAP), 0);
      chk("reset_done_fail", int'({DONE, FAIL}), 0);
      @(negedge CLK);
      RST = 1'b0;
      repeat (2) @(posedge CLK);

      // Back-to-back runs also exercise restart from DONE and from FAIL.
      for (int i = 0; i < NV; i++) begin
         start_run(tbl[i], 1'b1);
         wait_result(i);
      end

      // Reset while checking tap 20, then a clean realignment.
      start_run(rv, 1'b0);
      cyc = 0;
      while (!(tap_m == 20 && since_m == SETTLE + 5) && cyc < 5000) begin
         @(posedge CLK); #2;
         cyc++;
      end
      chk("midcheck_reached", int'(tap_m == 20 && since_m == SETTLE + 5), 1);
      chk("midcheck_tap", int'(TAP), 20);
      RST = 1'b1;
      #1;
      chk("midrst_pulses", int'({SRST, DRST, DINC, BS}), 0);
      chk("midrst_tap", int'(TAP), 0);
      chk("midrst_done_fail", int'({DONE, FAIL}), 0);
      run_id++;
      repeat (3) @(posedge CLK);
      #2 RST = 1'b0;
      repeat (20) @(posedge CLK);
      #2;
      chk("postrst_quiet", n_pulse, 0);
      $display("reset at tap 20: outputs cleared, %0d pulses while idle", n_pulse);
      start_run(rv, 1'b1);
      wait_result(NV);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/adc_align_ctrl.md
ADC_ALIGN_CTRL -- requirements
Module: adc_align_ctrl

Interface
REQ-001 Parameters (name, default, meaning): PATTERN, 6'b111000, ADC training word expected after alignment.
REQ-002 NSAMP, 16: consecutive identical words required for a tap to pass.
REQ-003 SETTLE, 8: CLK cycles waited after any DINC/DRST/BS/SRST before sampling.
REQ-004 MAXTAP, 255: highest IODELAY tap swept.
REQ-005 Ports: CLK in 1, single clock, also drives IODELAY DCLK. RST in 1, reset, asynchronous, active-high.
REQ-006 START in 1: one-cycle pulse, begins alignment; ignored unless state is IDLE, DONE or FAIL.
REQ-007 DIN in 6: deserialized word from the line receiver, CLK domain.
REQ-008 SRST out 1: ISERDES reset. DRST out 1: IODELAY reset. DINC out 1: IODELAY increment. BS out 1: bitslip.
REQ-009 TAP out 8: current IODELAY tap count. DONE out 1: level, aligned. FAIL out 1: level, alignment failed.

Function
REQ-010 States: IDLE, SRES, DRES, WAIT, CHECK, INC, RECEN, CENTER, SLIP, DONE, FAIL.
REQ-011 START -> SRES: SRST high 1 cycle; clear TAP, window registers, slip count; DONE=FAIL=0.
REQ-012 SRES -> DRES: DRST high 1 cycle, TAP=0 -> WAIT.
REQ-013 WAIT: count SETTLE cycles, then return to the state that issued the command (CHECK during sweep, CENTER or SLIP later).
REQ-014 CHECK: tap passes when NSAMP consecutive DIN equal each other and equal one of the 6 rotations of PATTERN; any mismatch fails the tap immediately.
REQ-015 Sweep: first passing tap stored as LO; subsequent passing taps update HI; first failing tap after LO ends the window.
REQ-016 Tap not final and window open -> INC: DINC high 1 cycle, TAP+1 -> WAIT -> CHECK.
REQ-017 Window closes, or TAP==MAXTAP: no pass seen -> FAIL; else -> RECEN.
REQ-018 RECEN: DRST 1 cycle, TAP=0, target C=(LO+HI)>>1 computed in 9 bits, then CENTER.
REQ-019 CENTER: one DINC pulse per SETTLE+1 cycles until TAP==C; C==0 issues none.
REQ-020 SLIP: if DIN==PATTERN -> DONE; else BS high 1 cycle, slip count+1 -> WAIT; after 6 slips without match -> FAIL.
REQ-021 DINC, DRST, BS, SRST are single-cycle pulses, mutually exclusive, never asserted in the same cycle.
REQ-022 TAP saturates at MAXTAP and never wraps.
REQ-023 START in DONE or FAIL restarts from SRES; START in any other non-IDLE state is ignored.
REQ-024 DIN change during WAIT is ignored.

Reset
REQ-025 RST asynchronous: state IDLE; all pulse outputs 0; TAP=0; DONE=FAIL=0; counters cleared.
REQ-026 RST mid-sweep aborts without issuing further pulses. The IODELAY is re-zeroed by the next START.

Configuration
REQ-027 ADC_ALIGN_DEBUG_EN defined: extra output WIN[15:0]={HI,LO}, valid from RECEN onward, cleared on START/RST.
REQ-028 ADC_ALIGN_DEBUG_EN undefined: no WIN port and no HI/LO export logic. Function otherwise identical.

Structure
REQ-029 Shared package adc_pkg: state enum, PATTERN default, rotation-compare constant width 6, MAXTAP default.
REQ-030 One sub-module adc_word_check: NSAMP stability counter plus rotation match, outputs pass/fail strobe.

Verification
REQ-031 Model passes taps 40..60, DIN rotated by 2: expect TAP settles 50, 4 BS pulses, DONE=1.
REQ-032 Model never passes: expect 255 DINC pulses, FAIL=1, TAP=255, no BS.
REQ-033 Window 0..0: expect C=0, no DINC in CENTER, then DONE.
REQ-034 Word never equals PATTERN after centering: expect 6 BS pulses, then FAIL.
REQ-035 RST asserted during CHECK at TAP=20: outputs zero same cycle; START then yields SRST, DRST, full sweep.
REQ-036 Single glitched word at sample 10 of tap 45: tap 45 fails and the window ends at 44.
